// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC, FSM encodings.
package ifu_fetch_pkg;

  localparam int unsigned AW     = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [AW-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_EXEC  = 3'd3,
    S_FAULT = 3'd4
  } ifu_state_e;

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus bundle: imem request/response, decode handoff, next-PC return and status.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [AW-1:0]     imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [AW-1:0]     inst_pc;
  logic              next_pc_valid;
  logic [AW-1:0]     next_pc;
  logic              fetch_fault;
  logic [63:0]       fetch_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault, fetch_cnt,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, next_pc_valid, next_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault, fetch_cnt,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready, next_pc_valid, next_pc
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, one-at-a-time imem fetch, decode handoff and
// retired-fetch counter. All outputs are registered from the next-state decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_if.master   io
);

  ifu_state_e        state, state_n;
  logic [AW-1:0]     pc, pc_n;
  logic [INST_W-1:0] inst_q, inst_n;
  logic [63:0]       cnt_q, cnt_n;
  logic              req_valid_q, req_valid_n;
  logic              inst_valid_q, inst_valid_n;
  logic              fault_q, fault_n;

  // State and datapath registers; req_valid stays low through reset and rises one cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      inst_q       <= '0;
      cnt_q        <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      inst_q       <= inst_n;
      cnt_q        <= cnt_n;
      req_valid_q  <= req_valid_n;
      inst_valid_q <= inst_valid_n;
      fault_q      <= fault_n;
    end
  end

  // Next state and register updates; inputs outside their owning state are ignored.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst_q;
    cnt_n   = cnt_q;
    unique case (state)
      S_REQ: begin
        if (req_valid_q && io.imem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (io.imem_resp_valid) begin
          inst_n  = io.imem_resp_data;
          state_n = S_OUT;
        end
      end
      S_OUT: begin
        if (inst_valid_q && io.inst_ready) begin
          cnt_n   = cnt_q + 64'd1;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (io.next_pc_valid) begin
          pc_n    = io.next_pc;
          state_n = pc_misaligned(io.next_pc[1:0]) ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_FAULT;
    endcase

    req_valid_n  = (state_n == S_REQ);
    inst_valid_n = (state_n == S_OUT);
    fault_n      = (state_n == S_FAULT);
  end

  assign io.imem_req_valid = req_valid_q;
  assign io.imem_req_addr  = pc;
  assign io.inst_valid     = inst_valid_q;
  assign io.inst           = inst_q;
  assign io.inst_pc        = pc;
  assign io.fetch_fault    = fault_q;
  assign io.fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: bench-side memory/execute models with a scoreboard of
// expected {pc, inst} pairs popped when the fetch unit presents an instruction.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if bus();

  ifu_fetch u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_out_cyc = 0;
  logic [63:0] exp_cnt = 64'd0;
  logic [95:0] exp_q[$];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
    bus.next_pc_valid   = 1'b0;
    bus.next_pc         = 64'h0;
  endtask

  // Async reset: reset values must appear without a clock edge.
  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_req_valid",  128'(bus.imem_req_valid), 128'(0));
    check("rst_inst_valid", 128'(bus.inst_valid),     128'(0));
    check("rst_fault",      128'(bus.fetch_fault),    128'(0));
    check("rst_cnt",        128'(bus.fetch_cnt),      128'(0));
    check("rst_pc",         128'(bus.inst_pc),        128'(RESET_PC));
    check("rst_inst",       128'(bus.inst),           128'(0));
    repeat (2) @(negedge clk);
    check("rst_hold_req_valid", 128'(bus.imem_req_valid), 128'(0));
    rst = 1'b0;
    exp_cnt = 64'd0;
    exp_q.delete();
  endtask

  // One full instruction: request (optional stall), response (delay), decode handshake
  // (optional stall), then a next-PC pulse. noise injects out-of-state inputs.
  task automatic do_fetch(input logic [63:0] exp_pc, input logic [31:0] data,
                          input int req_stall, input int resp_dly, input int rdy_stall,
                          input bit noise, input logic [63:0] npc);
    int n = 0;
    logic [95:0] e;
    exp_q.push_back({exp_pc, data});
    while (bus.imem_req_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_valid", 128'(bus.imem_req_valid), 128'(1));
    check("req_addr",  128'(bus.imem_req_addr),  128'(exp_pc));
    for (int i = 0; i < req_stall; i++) begin
      bus.imem_req_ready = 1'b0;
      if (noise) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      bus.imem_resp_valid = 1'b0;
      check("req_hold_valid", 128'(bus.imem_req_valid), 128'(1));
      check("req_hold_addr",  128'(bus.imem_req_addr),  128'(exp_pc));
    end
    bus.imem_req_ready = 1'b1;
    if (noise) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    check("req_dropped", 128'(bus.imem_req_valid), 128'(0));
    for (int i = 1; i < resp_dly; i++) begin
      if (noise) begin
        bus.next_pc_valid = 1'b1;
        bus.next_pc       = 64'h8000_0F00;
      end
      @(negedge clk);
      bus.next_pc_valid = 1'b0;
      check("wait_no_inst", 128'(bus.inst_valid), 128'(0));
      check("wait_pc",      128'(bus.inst_pc),    128'(exp_pc));
    end
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    check("inst_valid", 128'(bus.inst_valid), 128'(1));
    last_out_cyc = cyc;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 128'(0), 128'(1));
    end else begin
      e = exp_q.pop_front();
      check("sb_pc_inst", 128'({bus.inst_pc, bus.inst}), 128'(e));
    end
    for (int i = 0; i < rdy_stall; i++) begin
      bus.inst_ready = 1'b0;
      @(negedge clk);
      check("out_hold_valid", 128'(bus.inst_valid), 128'(1));
      check("out_hold_inst",  128'(bus.inst),       128'(data));
    end
    bus.inst_ready = 1'b1;
    if (noise) begin
      bus.next_pc_valid = 1'b1;
      bus.next_pc       = 64'h8000_0F00;
    end
    @(negedge clk);
    bus.inst_ready    = 1'b0;
    bus.next_pc_valid = 1'b0;
    exp_cnt = exp_cnt + 64'd1;
    check("fetch_cnt",      128'(bus.fetch_cnt),  128'(exp_cnt));
    check("exec_inst_lo",   128'(bus.inst_valid), 128'(0));
    check("exec_pc",        128'(bus.inst_pc),    128'(exp_pc));
    if (noise) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
      bus.inst_ready      = 1'b1;
      @(negedge clk);
      bus.imem_resp_valid = 1'b0;
      bus.inst_ready      = 1'b0;
      check("exec_inst_kept", 128'(bus.inst),      128'(data));
      check("exec_cnt_kept",  128'(bus.fetch_cnt), 128'(exp_cnt));
    end
    bus.next_pc_valid = 1'b1;
    bus.next_pc       = npc;
    @(negedge clk);
    bus.next_pc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    apply_reset();

    // Basic loop, sequential and jump targets.
    do_fetch(64'h8000_0000, 32'h0000_0413, 0, 1, 0, 1'b0, 64'h8000_0004);
    check("first_out_cycle", 128'(last_out_cyc), 128'(3));
    check("req_after_exec",  128'(bus.imem_req_valid), 128'(1));
    do_fetch(64'h8000_0004, 32'h0010_0093, 0, 1, 0, 1'b0, 64'h8000_1000);
    do_fetch(64'h8000_1000, 32'h0020_8113, 3, 5, 2, 1'b1, 64'h8000_1004);
    do_fetch(64'h8000_1004, 32'h0031_0193, 0, 1, 0, 1'b1, 64'h8000_0006);

    // Misaligned target: sticky fault, no further requests.
    check("fault_set",      128'(bus.fetch_fault),    128'(1));
    check("fault_pc",       128'(bus.inst_pc),        128'(64'h8000_0006));
    check("fault_no_req",   128'(bus.imem_req_valid), 128'(0));
    for (int i = 0; i < 4; i++) begin
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b1;
      bus.inst_ready      = 1'b1;
      bus.next_pc_valid   = 1'b1;
      bus.next_pc         = 64'h8000_0000;
      @(negedge clk);
      check("fault_sticky", 128'({bus.fetch_fault, bus.imem_req_valid, bus.inst_valid}),
            128'(3'b100));
    end
    idle_inputs();

    // Reset recovers from fault; then reset mid-wait abandons the request.
    apply_reset();
    check("fault_cleared", 128'(bus.fetch_fault), 128'(0));
    do_fetch(64'h8000_0000, 32'h0000_0413, 0, 1, 0, 1'b0, 64'h8000_0008);
    @(negedge clk);
    check("mid_req_addr", 128'(bus.imem_req_addr), 128'(64'h8000_0008));
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_req_valid",  128'(bus.imem_req_valid), 128'(0));
    check("midrst_inst_valid", 128'(bus.inst_valid),     128'(0));
    check("midrst_cnt",        128'(bus.fetch_cnt),      128'(0));
    check("midrst_pc",         128'(bus.inst_pc),        128'(RESET_PC));
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 64'd0;
    exp_q.delete();
    do_fetch(64'h8000_0000, 32'h0000_0513, 0, 1, 0, 1'b0, 64'h8000_0004);
    check("refetch_cnt", 128'(bus.fetch_cnt), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: owns the architectural PC register, which is the consumer of the next-PC value computed by the next-PC select logic. It issues one instruction-memory read per instruction over a valid/ready request channel, captures the 32-bit response, and presents it with its PC to decode. It then waits for the execute stage to return the next PC before fetching again. It sits between instruction memory and the decode/execute path of the npc core and keeps a retired-fetch counter for difftrace/perf.

## Interface
- RESET_PC, 64'h8000_0000, PC loaded on reset.
- AW, `CPU_WIDTH, address/PC width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  AW  fetch address (equals pc).
- imem_resp_valid  in  1  read data valid.
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  captured instruction.
- inst_pc  out  AW  PC of inst.
- next_pc_valid  in  1  execute has produced next PC (one-cycle pulse).
- next_pc  in  AW  next PC from next-PC select.
- fetch_fault  out  1  sticky misaligned-PC fault.
- fetch_cnt  out  64  instructions handed to decode since reset.

## Operation
- Five-state FSM:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. On req_valid&&req_ready go to S_WAIT.
  - S_WAIT: on imem_resp_valid, latch imem_resp_data into inst and go to S_OUT.
  - S_OUT: inst_valid=1. On inst_valid&&inst_ready, increment fetch_cnt and go to S_EXEC.
  - S_EXEC: on next_pc_valid, load pc<=next_pc. If next_pc[1:0]!=0, go to S_FAULT; else go to S_REQ.
  - S_FAULT: fetch_fault=1. All valids are 0. Exit only by reset.
- inst_pc is always the pc register. pc changes only in S_EXEC and on reset.
- Inputs outside their state are ignored with no side effect: imem_resp_valid outside S_WAIT, next_pc_valid outside S_EXEC, inst_ready outside S_OUT.
- imem_req_addr and inst hold stable while their valid is high and not yet accepted.
- fetch_cnt is 64-bit and wraps from all-ones to 0.

## Timing
- Reset (async assert) values: state=S_REQ, pc=RESET_PC, inst=32'h0, fetch_cnt=0, fetch_fault=0.
  - imem_req_valid is forced 0 while rst=1 and goes 1 in the first cycle after deassertion.
  - inst_valid=0.
- All state and register updates occur on the rising clk edge. Outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Minimum loop is 4 cycles per instruction (REQ, WAIT, OUT, EXEC), with a one-cycle response, inst_ready=1 and a same-cycle next_pc_valid.
- Response is never earlier than the cycle after request acceptance. A response in the acceptance cycle is dropped.
- Reset asserted mid-fetch: abandon the outstanding request. After reset, the first response seen in S_WAIT belongs to the new request; the memory model must not return stale data.
- Simultaneous inst_ready and next_pc_valid in S_OUT: next_pc_valid is ignored. The execute stage must not pulse it before the handshake.

## Structure
- In the shared defines include: IFU state encodings (3-bit localparams S_REQ/S_WAIT/S_OUT/S_EXEC/S_FAULT), the default RESET_PC, and the 32-bit instruction width macro.
- No sub-module is natural. This is a single module holding the FSM, PC register, instruction register and counter.

## Test plan
- Reset release, imem ready and 1-cycle response 32'h00000413: req_addr=0x80000000 in cycle 1; inst_valid in cycle 3 with inst=0x00000413 and inst_pc=0x80000000; fetch_cnt=1 after the handshake.
- next_pc=0x80000004 pulsed in S_EXEC: next req_addr=0x80000004. Jump to next_pc=0x80001000: next req_addr=0x80001000.
- req_ready low 3 cycles, then resp delayed 5 cycles, then inst_ready low 2 cycles: req_addr, inst and inst_valid held stable throughout; exactly one fetch_cnt increment.
- next_pc=0x80000006: fetch_fault=1 next cycle, no further imem_req_valid, pc=0x80000006. Recovers only on rst.
- Spurious imem_resp_valid with data 0xDEADBEEF in S_REQ and S_EXEC: inst unchanged. next_pc_valid during S_WAIT: pc unchanged.
- rst asserted for 1 cycle while in S_WAIT: outputs immediately return to reset values; the refetch is from 0x80000000 and fetch_cnt=0.
